// File: rtl/countdown_pkg.sv
// Shared types and helpers for the countdown alarm controller: FSM states with
// their one-hot LED codes, the BCD time record and the 7-segment encoder.
package countdown_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    RUN   = 4'b0010,
    PAUSE = 4'b0100,
    ALARM = 4'b1000
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = '0;
  localparam bcd_time_t TIME_ONE  = '{min_tens: 4'd0, min_units: 4'd0,
                                      sec_tens: 4'd0, sec_units: 4'd1};

  // Active-low segments, bit0=a .. bit6=g; anything outside 0-9 is blank.
  function automatic logic [6:0] seg7_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic bcd_time_t minutes_to_bcd(input logic [3:0] m);
    bcd_time_t t;
    t = TIME_ZERO;
    if (m >= 4'd10) begin
      t.min_tens  = 4'd1;
      t.min_units = m - 4'd10;
    end else begin
      t.min_units = m;
    end
    return t;
  endfunction

  // One-second decrement with BCD borrows; caller guarantees t != 00:00.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_units != 4'd0) begin
      r.sec_units = t.sec_units - 4'd1;
    end else begin
      r.sec_units = 4'd9;
      if (t.sec_tens != 4'd0) begin
        r.sec_tens = t.sec_tens - 4'd1;
      end else begin
        r.sec_tens = 4'd5;
        if (t.min_units != 4'd0) begin
          r.min_units = t.min_units - 4'd1;
        end else begin
          r.min_units = 4'd9;
          r.min_tens  = t.min_tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchroniser, stability counter,
// and a single-cycle press pulse on each accepted high-to-low transition.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        // Level differed for DEBOUNCE_CYC consecutive samples: accept it.
        cnt    <= '0;
        stable <= sync2;
        press  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/countdown_alarm_ctrl.sv
// Kitchen-timer controller: MM:SS BCD countdown with start/pause/clear buttons,
// 7-segment display, state LEDs and timed buzzer. Optional PAUSE_BLINK_EN macro.
module countdown_alarm_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = 500_000,
  parameter int unsigned BUZZ_DIV     = 12_500,
  parameter int unsigned ALARM_SEC    = 5
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic [1:0] btn_export,
  input  logic [3:0] switches_export,
  output logic [6:0] seg_0_export,
  output logic [6:0] seg_1_export,
  output logic [6:0] seg_2_export,
  output logic [6:0] seg_3_export,
  output logic [4:0] leds_export,
  output logic       buzzer_export
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned BW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
  localparam int unsigned AW = $clog2(ALARM_SEC + 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);

  logic press0, press1;
  logic ev_start, ev_clear;

  state_t        state_q, state_d;
  bcd_time_t     count_q;
  logic [PW-1:0] presc_q, presc_adv;
  logic [AW-1:0] alarm_q;
  logic [BW-1:0] buzz_cnt_q;
  logic          buzz_q;
  logic [6:0]    seg0_q, seg1_q, seg2_q, seg3_q;
  logic [4:0]    leds_q;

  logic tick, last_sec;
  logic presc_run, load_sw, count_dec_en, led_blink, buzz_en, pause_blank;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn0 (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .btn_n (btn_export[0]),
    .press (press0)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn1 (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .btn_n (btn_export[1]),
    .press (press1)
  );

  // Clear/ack has priority when both buttons fire together.
  assign ev_clear  = press1;
  assign ev_start  = press0 & ~press1;
  assign tick      = (presc_q == PRESC_MAX);
  assign last_sec  = (count_q == TIME_ONE);
  assign presc_adv = tick ? '0 : presc_q + 1'b1;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (ev_start && switches_export != '0) state_d = RUN;
      RUN: begin
        if (ev_clear)              state_d = IDLE;
        else if (ev_start)         state_d = PAUSE;
        else if (tick && last_sec) state_d = ALARM;
      end
      PAUSE: begin
        if (ev_clear)      state_d = IDLE;
        else if (ev_start) state_d = RUN;
      end
      ALARM: if (ev_clear || (tick && alarm_q == AW'(ALARM_SEC - 1))) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_run    = 1'b0;
    load_sw      = 1'b0;
    count_dec_en = 1'b0;
    led_blink    = 1'b0;
    buzz_en      = 1'b0;
    pause_blank  = 1'b0;
    unique case (state_q)
      IDLE: load_sw = 1'b1;
      RUN: begin
        presc_run    = 1'b1;
        count_dec_en = tick;
        led_blink    = (presc_q < PRESC_HALF);
      end
      PAUSE: begin
`ifdef PAUSE_BLINK_EN
        presc_run   = 1'b1;
        pause_blank = (presc_q < PRESC_HALF);
`else
        presc_run   = 1'b0;
        pause_blank = 1'b0;
`endif
      end
      ALARM: begin
        presc_run = 1'b1;
        buzz_en   = (presc_q < PRESC_HALF);
      end
      default: ;
    endcase
  end

`ifdef PAUSE_BLINK_EN
  logic [PW-1:0] presc_save_q;

  // The prescaler free-runs in PAUSE for blink timing, so its RUN phase is
  // parked here on entry and restored on resume.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      presc_save_q <= '0;
    end else if (state_q == RUN && state_d == PAUSE) begin
      presc_save_q <= presc_adv;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)                            presc_q <= '0;
    else if (state_q == IDLE)                   presc_q <= '0;
    else if (state_q == PAUSE && state_d == RUN) presc_q <= presc_save_q;
    else if (presc_run)                         presc_q <= presc_adv;
  end
`else
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)          presc_q <= '0;
    else if (state_q == IDLE) presc_q <= '0;
    else if (presc_run)       presc_q <= presc_adv;
  end
`endif

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)            alarm_q <= '0;
    else if (state_q != ALARM)  alarm_q <= '0;
    else if (tick)              alarm_q <= alarm_q + 1'b1;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      count_q <= TIME_ZERO;
    end else if (load_sw) begin
      count_q <= minutes_to_bcd(switches_export);
    end else if (count_dec_en && count_q != TIME_ZERO) begin
      count_q <= bcd_dec(count_q);
    end
  end

  // Divider is held clear outside the beep window, which also clears it on ALARM entry.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      buzz_cnt_q <= '0;
      buzz_q     <= 1'b0;
    end else if (buzz_en) begin
      if (buzz_cnt_q == BW'(BUZZ_DIV - 1)) begin
        buzz_cnt_q <= '0;
        buzz_q     <= ~buzz_q;
      end else begin
        buzz_cnt_q <= buzz_cnt_q + 1'b1;
      end
    end else begin
      buzz_cnt_q <= '0;
      buzz_q     <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      seg0_q <= SEG_BLANK;
      seg1_q <= SEG_BLANK;
      seg2_q <= SEG_BLANK;
      seg3_q <= SEG_BLANK;
      leds_q <= 5'b00001;
    end else begin
      if (pause_blank) begin
        seg0_q <= SEG_BLANK;
        seg1_q <= SEG_BLANK;
        seg2_q <= SEG_BLANK;
        seg3_q <= SEG_BLANK;
      end else begin
        seg0_q <= seg7_enc(count_q.sec_units);
        seg1_q <= seg7_enc(count_q.sec_tens);
        seg2_q <= seg7_enc(count_q.min_units);
        seg3_q <= seg7_enc(count_q.min_tens);
      end
      leds_q <= {led_blink, state_q};
    end
  end

  assign seg_0_export  = seg0_q;
  assign seg_1_export  = seg1_q;
  assign seg_2_export  = seg2_q;
  assign seg_3_export  = seg3_q;
  assign leds_export   = leds_q;
  assign buzzer_export = buzz_q;

endmodule

// File: tb/tb_countdown_alarm_ctrl.sv
// Directed bench for countdown_alarm_ctrl with shortened timing parameters.
`timescale 1ns/1ps
module tb_countdown_alarm_ctrl;

  localparam logic [6:0] D0 = 7'h40, D1 = 7'h79, D2 = 7'h24, D3 = 7'h30;
  localparam logic [6:0] D4 = 7'h19, D5 = 7'h12, D9 = 7'h10, BL = 7'h7F;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] btn = 2'b11;
  logic [3:0] sw  = 4'd2;
  logic [6:0] s0, s1, s2, s3;
  logic [4:0] leds;
  logic       buz;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  countdown_alarm_ctrl #(
    .CLK_HZ(100), .DEBOUNCE_CYC(4), .BUZZ_DIV(5), .ALARM_SEC(3)
  ) dut (
    .clk_clk(clk), .reset_reset(rst), .btn_export(btn), .switches_export(sw),
    .seg_0_export(s0), .seg_1_export(s1), .seg_2_export(s2), .seg_3_export(s3),
    .leds_export(leds), .buzzer_export(buz)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_leds(input logic [3:0] exp, input int budget, output int waited);
    waited = 0;
    while (leds[3:0] !== exp && waited < budget) begin
      cyc(1);
      waited++;
    end
  endtask

  task automatic test_reset;
    cyc(3);
    n_checks++;
    if ({s3, s2, s1, s0} !== {BL, BL, BL, BL}) begin
      n_fail++; $display("FAIL reset_blank: got %h want %h", {s3, s2, s1, s0}, {BL, BL, BL, BL});
    end
    n_checks++;
    if (leds !== 5'b00001 || buz !== 1'b0) begin
      n_fail++; $display("FAIL reset_leds_buz: got %b/%b want 00001/0", leds, buz);
    end
    rst = 1'b0;
    cyc(1);
    n_checks++;
    if ({s3, s2, s1, s0} !== {D0, D0, D0, D0}) begin
      n_fail++; $display("FAIL reset_first_cycle: got %h want %h", {s3, s2, s1, s0}, {D0, D0, D0, D0});
    end
    cyc(1);
    n_checks++;
    if ({s3, s2, s1, s0} !== {D0, D2, D0, D0}) begin
      n_fail++; $display("FAIL reset_0200: got %h want %h", {s3, s2, s1, s0}, {D0, D2, D0, D0});
    end
  endtask

  task automatic test_run_to_alarm;
    int toggles, late_high;
    logic prev;
    sw = 4'd1;
    cyc(2);
    btn[0] = 1'b0;
    cyc(7);
    n_checks++;
    if (leds[3:0] !== 4'b0001) begin
      n_fail++; $display("FAIL start_latency_early: got %b want 0001", leds[3:0]);
    end
    cyc(1);
    n_checks++;
    if (leds !== 5'b10010) begin
      n_fail++; $display("FAIL start_run_leds: got %b want 10010", leds);
    end
    btn[0] = 1'b1;
    cyc(99);
    n_checks++;
    if ({s3, s2, s1, s0} !== {D0, D1, D0, D0}) begin
      n_fail++; $display("FAIL before_first_tick: got %h want %h", {s3, s2, s1, s0}, {D0, D1, D0, D0});
    end
    cyc(1);
    n_checks++;
    if ({s3, s2, s1, s0} !== {D0, D0, D5, D9}) begin
      n_fail++; $display("FAIL first_tick_0059: got %h want %h", {s3, s2, s1, s0}, {D0, D0, D5, D9});
    end
    cyc(5899);
    n_checks++;
    if (leds[3:0] !== 4'b0010) begin
      n_fail++; $display("FAIL pre_alarm_run: got %b want 0010", leds[3:0]);
    end
    cyc(1);
    n_checks++;
    if (leds !== 5'b01000 || {s3, s2, s1, s0} !== {D0, D0, D0, D0}) begin
      n_fail++; $display("FAIL alarm_entry: got leds %b digits %h want 01000 %h", leds, {s3, s2, s1, s0}, {D0, D0, D0, D0});
    end
    cyc(3);
    n_checks++;
    if (buz !== 1'b0) begin
      n_fail++; $display("FAIL buz_before_first_toggle: got %b want 0", buz);
    end
    cyc(1);
    n_checks++;
    if (buz !== 1'b1) begin
      n_fail++; $display("FAIL buz_first_toggle: got %b want 1", buz);
    end
    prev = buz;
    toggles = 0;
    late_high = 0;
    for (int i = 6; i <= 100; i++) begin
      cyc(1);
      if (buz !== prev) toggles++;
      prev = buz;
      if (i > 50 && buz !== 1'b0) late_high++;
    end
    n_checks++;
    if (toggles != 9 || late_high != 0) begin
      n_fail++; $display("FAIL buz_pattern: got toggles %0d late_high %0d want 9 0", toggles, late_high);
    end
  endtask

  task automatic test_alarm_timeout;
    cyc(200);
    n_checks++;
    if (leds[3:0] !== 4'b1000) begin
      n_fail++; $display("FAIL alarm_hold: got %b want 1000", leds[3:0]);
    end
    cyc(1);
    n_checks++;
    if (leds !== 5'b00001 || buz !== 1'b0) begin
      n_fail++; $display("FAIL alarm_timeout: got %b/%b want 00001/0", leds, buz);
    end
    sw = 4'd3;
    cyc(2);
    n_checks++;
    if ({s3, s2, s1, s0} !== {D0, D3, D0, D0}) begin
      n_fail++; $display("FAIL idle_tracks_sw: got %h want %h", {s3, s2, s1, s0}, {D0, D3, D0, D0});
    end
  endtask

  task automatic test_pause;
    sw = 4'd1;
    cyc(2);
    btn[0] = 1'b0;
    cyc(8);
    btn[0] = 1'b1;
    n_checks++;
    if (leds[3:0] !== 4'b0010) begin
      n_fail++; $display("FAIL pause_start: got %b want 0010", leds[3:0]);
    end
    cyc(1528);
    n_checks++;
    if ({s3, s2, s1, s0} !== {D0, D0, D4, D5}) begin
      n_fail++; $display("FAIL count_0045: got %h want %h", {s3, s2, s1, s0}, {D0, D0, D4, D5});
    end
    btn[0] = 1'b0;
    cyc(7);
    n_checks++;
    if (leds[3:0] !== 4'b0010) begin
      n_fail++; $display("FAIL pause_latency_early: got %b want 0010", leds[3:0]);
    end
    cyc(1);
    btn[0] = 1'b1;
    n_checks++;
    if (leds !== 5'b00100) begin
      n_fail++; $display("FAIL pause_leds: got %b want 00100", leds);
    end
    cyc(200);
    n_checks++;
    if ({s3, s2, s1, s0} !== {D0, D0, D4, D5} || leds !== 5'b00100) begin
      n_fail++; $display("FAIL pause_frozen: got %h/%b want %h/00100", {s3, s2, s1, s0}, leds, {D0, D0, D4, D5});
    end
    btn[0] = 1'b0;
    cyc(8);
    btn[0] = 1'b1;
    n_checks++;
    if (leds !== 5'b10010) begin
      n_fail++; $display("FAIL resume_leds: got %b want 10010", leds);
    end
    cyc(63);
    n_checks++;
    if ({s3, s2, s1, s0} !== {D0, D0, D4, D5}) begin
      n_fail++; $display("FAIL resume_phase_early: got %h want %h", {s3, s2, s1, s0}, {D0, D0, D4, D5});
    end
    cyc(1);
    n_checks++;
    if ({s3, s2, s1, s0} !== {D0, D0, D4, D4}) begin
      n_fail++; $display("FAIL resume_phase_tick: got %h want %h", {s3, s2, s1, s0}, {D0, D0, D4, D4});
    end
  endtask

  task automatic test_both_buttons;
    btn = 2'b00;
    cyc(7);
    n_checks++;
    if (leds[3:0] !== 4'b0010) begin
      n_fail++; $display("FAIL both_early: got %b want 0010", leds[3:0]);
    end
    cyc(1);
    n_checks++;
    if (leds !== 5'b00001) begin
      n_fail++; $display("FAIL both_to_idle: got %b want 00001", leds);
    end
    btn = 2'b11;
    cyc(1);
    n_checks++;
    if ({s3, s2, s1, s0} !== {D0, D1, D0, D0}) begin
      n_fail++; $display("FAIL both_reload: got %h want %h", {s3, s2, s1, s0}, {D0, D1, D0, D0});
    end
  endtask

  task automatic test_bounce;
    int bad, waited;
    sw = 4'd2;
    cyc(10);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      btn[0] = 1'b0;
      cyc(1); if (leds[3:0] !== 4'b0001) bad++;
      cyc(1); if (leds[3:0] !== 4'b0001) bad++;
      btn[0] = 1'b1;
      cyc(1); if (leds[3:0] !== 4'b0001) bad++;
      cyc(1); if (leds[3:0] !== 4'b0001) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL bounce_no_event: got %0d bad cycles want 0", bad);
    end
    btn[0] = 1'b0;
    wait_leds(4'b0010, 20, waited);
    n_checks++;
    if (waited != 8) begin
      n_fail++; $display("FAIL bounce_start_latency: got %0d want 8", waited);
    end
    cyc(40);
    n_checks++;
    if (leds[3:0] !== 4'b0010) begin
      n_fail++; $display("FAIL hold_single_event: got %b want 0010", leds[3:0]);
    end
    btn[0] = 1'b1;
    cyc(20);
    n_checks++;
    if (leds[3:0] !== 4'b0010) begin
      n_fail++; $display("FAIL release_no_event: got %b want 0010", leds[3:0]);
    end
    btn[1] = 1'b0;
    cyc(8);
    btn[1] = 1'b1;
    n_checks++;
    if (leds[3:0] !== 4'b0001) begin
      n_fail++; $display("FAIL clear_to_idle: got %b want 0001", leds[3:0]);
    end
  endtask

  task automatic test_zero_switch;
    sw = 4'd0;
    cyc(12);
    btn[0] = 1'b0;
    cyc(12);
    btn[0] = 1'b1;
    cyc(10);
    n_checks++;
    if (leds !== 5'b00001 || {s3, s2, s1, s0} !== {D0, D0, D0, D0}) begin
      n_fail++; $display("FAIL zero_ignored: got %b %h want 00001 %h", leds, {s3, s2, s1, s0}, {D0, D0, D0, D0});
    end
  endtask

  task automatic test_alarm_ack;
    int waited;
    sw = 4'd1;
    cyc(2);
    btn[0] = 1'b0;
    cyc(8);
    btn[0] = 1'b1;
    wait_leds(4'b1000, 6100, waited);
    n_checks++;
    if (waited != 6000) begin
      n_fail++; $display("FAIL ack_alarm_time: got %0d want 6000", waited);
    end
    btn[0] = 1'b0;
    cyc(12);
    btn[0] = 1'b1;
    cyc(8);
    n_checks++;
    if (leds[3:0] !== 4'b1000) begin
      n_fail++; $display("FAIL alarm_btn0_ignored: got %b want 1000", leds[3:0]);
    end
    btn[1] = 1'b0;
    cyc(7);
    n_checks++;
    if (leds[3:0] !== 4'b1000) begin
      n_fail++; $display("FAIL ack_early: got %b want 1000", leds[3:0]);
    end
    cyc(1);
    btn[1] = 1'b1;
    n_checks++;
    if (leds !== 5'b00001 || buz !== 1'b0) begin
      n_fail++; $display("FAIL ack_to_idle: got %b/%b want 00001/0", leds, buz);
    end
  endtask

  task automatic test_reset_midrun;
    sw = 4'd1;
    cyc(10);
    btn[0] = 1'b0;
    cyc(8);
    btn[0] = 1'b1;
    cyc(50);
    n_checks++;
    if (leds[3:0] !== 4'b0010) begin
      n_fail++; $display("FAIL midrun_running: got %b want 0010", leds[3:0]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({s3, s2, s1, s0} !== {BL, BL, BL, BL} || leds !== 5'b00001 || buz !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got %h %b %b want %h 00001 0", {s3, s2, s1, s0}, leds, buz, {BL, BL, BL, BL});
    end
    cyc(3);
    rst = 1'b0;
    cyc(2);
    n_checks++;
    if (leds !== 5'b00001 || {s3, s2, s1, s0} !== {D0, D1, D0, D0}) begin
      n_fail++; $display("FAIL after_reset_idle: got %b %h want 00001 %h", leds, {s3, s2, s1, s0}, {D0, D1, D0, D0});
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_run_to_alarm();
    test_alarm_timeout();
    test_pause();
    test_both_buttons();
    test_bounce();
    test_zero_switch();
    test_alarm_ack();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
